// File: rtl/ball_crash_detect.sv
// ball_crash_detect: frame-rate collision stage for the ball logic.
// It evaluates the ball against walls and paddles once per frame and produces
// the {left, right, up, down} crash vector. It also scores missed returns and
// holds a sticky game-over flag.
module ball_crash_detect #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned WALL_MARGIN = 2,
    parameter int unsigned PAD_L_X     = 16,
    parameter int unsigned PAD_R_X     = 616,
    parameter int unsigned PAD_W       = 8,
    parameter int unsigned PAD_H       = 64,
    parameter int unsigned SCORE_MAX   = 9
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFrame_CLK,
    input  logic [9:0] iBall_x,
    input  logic [9:0] iBall_y,
    input  logic [9:0] iPad_l_y,
    input  logic [9:0] iPad_r_y,
    output logic [3:0] oCrash,
    output logic [3:0] oScore_l,
    output logic [3:0] oScore_r,
    output logic       oMiss,
    output logic       oGame_over,
    output logic [1:0] oState
);

    // Evaluation sequencer. ARM waits for a frame rise. SAMPLE takes the
    // stable inputs and registers the results on its closing edge. UPDATE
    // ends the one-cycle miss pulse and returns to ARM.
    // There is no handshake: iFrame_CLK is a level sampled every cycle, and
    // a rise is only accepted in ARM.
    typedef enum logic [1:0] {
        ARM    = 2'd0,
        SAMPLE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [10:0] C_BALL   = 11'(BALL_SIZE);
    localparam logic [10:0] C_MARGIN = 11'(WALL_MARGIN);
    localparam logic [10:0] C_BOTTOM = 11'(SCREEN_H - WALL_MARGIN);
    localparam logic [10:0] C_RIGHT  = 11'(SCREEN_W - WALL_MARGIN);
    localparam logic [10:0] C_PL_X   = 11'(PAD_L_X);
    localparam logic [10:0] C_PL_END = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] C_PR_X   = 11'(PAD_R_X);
    localparam logic [10:0] C_PR_END = 11'(PAD_R_X + PAD_W);
    localparam logic [10:0] C_PAD_H  = 11'(PAD_H);
    localparam logic [3:0]  C_SMAX   = 4'(SCORE_MAX);

    state_t      r_state;
    logic        r_frame_q;
    logic [3:0]  r_crash;
    logic [3:0]  r_score_l;
    logic [3:0]  r_score_r;
    logic        r_miss;
    logic        r_game_over;
    logic        r_miss_l_q;
    logic        r_miss_r_q;

    logic        w_rise;
    logic [10:0] w_bx, w_by, w_pl, w_pr;
    logic [10:0] w_bx_end, w_by_end;
    logic        w_v_l, w_v_r;
    logic        w_up, w_down, w_wall_l, w_wall_r, w_pad_l, w_pad_r;
    logic        w_inc_l, w_inc_r;
    logic [3:0]  w_next_l, w_next_r;

    assign w_rise = iFrame_CLK & ~r_frame_q;

    // All geometry is done in 11 bits, so ball/paddle sums never wrap.
    assign w_bx     = {1'b0, iBall_x};
    assign w_by     = {1'b0, iBall_y};
    assign w_pl     = {1'b0, iPad_l_y};
    assign w_pr     = {1'b0, iPad_r_y};
    assign w_bx_end = w_bx + C_BALL;
    assign w_by_end = w_by + C_BALL;

    assign w_v_l    = (w_by_end > w_pl) & (w_by < w_pl + C_PAD_H);
    assign w_v_r    = (w_by_end > w_pr) & (w_by < w_pr + C_PAD_H);
    assign w_up     = (w_by <= C_MARGIN);
    assign w_down   = (w_by_end >= C_BOTTOM);
    assign w_wall_l = (w_bx <= C_MARGIN);
    assign w_wall_r = (w_bx_end >= C_RIGHT);
    assign w_pad_l  = w_v_l & (w_bx <= C_PL_END) & (w_bx_end > C_PL_X);
    assign w_pad_r  = w_v_r & (w_bx_end >= C_PR_X) & (w_bx < C_PR_END);

    // A left-wall hit scores for the right player and a right-wall hit for
    // the left player. Only the first frame of each wall contact counts.
    assign w_inc_r  = w_wall_l & ~r_miss_l_q & ~r_game_over & (r_score_r < C_SMAX);
    assign w_inc_l  = w_wall_r & ~r_miss_r_q & ~r_game_over & (r_score_l < C_SMAX);
    assign w_next_l = r_score_l + {3'b000, w_inc_l};
    assign w_next_r = r_score_r + {3'b000, w_inc_r};

    // Frame edge detection, sequencer and all registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= ARM;
            r_frame_q   <= 1'b0;
            r_crash     <= 4'd0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_miss      <= 1'b0;
            r_game_over <= 1'b0;
            r_miss_l_q  <= 1'b0;
            r_miss_r_q  <= 1'b0;
        end else begin
            r_frame_q <= iFrame_CLK;
            case (r_state)
                ARM: begin
                    r_miss <= 1'b0;
                    if (w_rise) r_state <= SAMPLE;
                end
                SAMPLE: begin
                    // The inputs are stable throughout this cycle. The
                    // evaluation is captured here so results show up one
                    // cycle later, in UPDATE.
                    r_crash     <= {w_pad_l | w_wall_l, w_pad_r | w_wall_r, w_up, w_down};
                    r_miss_l_q  <= w_wall_l;
                    r_miss_r_q  <= w_wall_r;
                    r_score_l   <= w_next_l;
                    r_score_r   <= w_next_r;
                    r_miss      <= w_inc_l | w_inc_r;
                    r_game_over <= r_game_over | (w_next_l == C_SMAX) | (w_next_r == C_SMAX);
                    r_state     <= UPDATE;
                end
                UPDATE: begin
                    r_miss  <= 1'b0;
                    r_state <= ARM;
                end
                default: begin
                    r_miss  <= 1'b0;
                    r_state <= ARM;
                end
            endcase
        end
    end

    assign oCrash     = r_crash;
    assign oScore_l   = r_score_l;
    assign oScore_r   = r_score_r;
    assign oMiss      = r_miss;
    assign oGame_over = r_game_over;
    assign oState     = r_state;

endmodule

// File: tb/tb_ball_crash_detect.sv
// Directed bench for ball_crash_detect. A small reference model predicts
// each frame's outputs, and the scoreboard compares them at the result cycle.
module tb_ball_crash_detect;

    localparam logic [1:0] ST_ARM = 2'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic [9:0] ball_x, ball_y, pad_l, pad_r;
    logic [3:0] crash, score_l, score_r;
    logic       miss, game_over;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Expected output word: {crash, score_l, score_r, miss, game_over}.
    logic [13:0] exp_q[$];
    logic [13:0] held;

    // Reference model state.
    int   m_sl, m_sr;
    logic m_go, m_ml, m_mr;

    ball_crash_detect dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iFrame_CLK (frame),
        .iBall_x    (ball_x),
        .iBall_y    (ball_y),
        .iPad_l_y   (pad_l),
        .iPad_r_y   (pad_r),
        .oCrash     (crash),
        .oScore_l   (score_l),
        .oScore_r   (score_r),
        .oMiss      (miss),
        .oGame_over (game_over),
        .oState     (state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [13:0] outs();
        return {crash, score_l, score_r, miss, game_over};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: actual=%h required=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sl = 0; m_sr = 0; m_go = 1'b0; m_ml = 1'b0; m_mr = 1'b0;
        held = 14'd0;
    endtask

    // Predict one evaluation and push the expected output word.
    task automatic model_frame(input int bx, input int by, input int pl, input int pr);
        logic vl, vr, up, dn, wl, wr, pdl, pdr, il, ir;
        vl  = (by + 8 > pl) && (by < pl + 64);
        vr  = (by + 8 > pr) && (by < pr + 64);
        up  = (by <= 2);
        dn  = (by + 8 >= 478);
        wl  = (bx <= 2);
        wr  = (bx + 8 >= 638);
        pdl = vl && (bx <= 24) && (bx + 8 > 16);
        pdr = vr && (bx + 8 >= 616) && (bx < 624);
        ir  = wl && !m_ml && !m_go && (m_sr < 9);
        il  = wr && !m_mr && !m_go && (m_sl < 9);
        if (ir) m_sr++;
        if (il) m_sl++;
        if (m_sl == 9 || m_sr == 9) m_go = 1'b1;
        m_ml = wl;
        m_mr = wr;
        exp_q.push_back({pdl | wl, pdr | wr, up, dn, 4'(m_sl), 4'(m_sr), il | ir, m_go});
    endtask

    // One full frame: rise in cycle t, check held values at t+1,
    // new results at t+2, end of miss pulse at t+3, then idle.
    task automatic do_frame(input string tag, input int bx, input int by, input int pl, input int pr);
        logic [13:0] e;
        @(posedge clk); #1;
        ball_x = 10'(bx); ball_y = 10'(by); pad_l = 10'(pl); pad_r = 10'(pr);
        frame = 1'b1;
        model_frame(bx, by, pl, pr);
        @(negedge clk);
        @(negedge clk);
        check({tag, " t+1 held"}, outs(), held);
        frame = 1'b0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: actual=empty required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " t+2"}, outs(), e);
            held = {e[13:2], 1'b0, e[0]};
        end
        @(negedge clk);
        check({tag, " t+3 miss off"}, outs(), held);
        check({tag, " t+3 state"}, {12'd0, state}, {12'd0, ST_ARM});
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0;
        ball_x = '0; ball_y = '0; pad_l = '0; pad_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs", outs(), 14'd0);
        check("reset state", {12'd0, state}, {12'd0, ST_ARM});
        @(posedge clk); #1;
        rst = 1'b0;

        do_frame("center", 320, 240, 200, 200);
        do_frame("top wall", 100, 2, 200, 200);
        do_frame("bottom wall", 100, 470, 200, 200);
        do_frame("corner miss", 2, 2, 200, 200);
        do_frame("left pad hit", 24, 220, 200, 200);
        do_frame("left pad gap", 24, 220, 300, 200);
        do_frame("right pad hit", 610, 220, 200, 200);
        do_frame("right wall", 630, 100, 200, 200);

        // Three frames at the left wall score once.
        do_frame("wall hold 1", 2, 240, 200, 200);
        do_frame("wall hold 2", 2, 240, 200, 200);
        do_frame("wall hold 3", 2, 240, 200, 200);
        do_frame("away", 100, 240, 200, 200);
        do_frame("wall again", 2, 240, 200, 200);

        // Run the right player's score up to the end of the game.
        for (int k = 0; k < 12 && !m_go; k++) begin
            do_frame("run away", 100, 240, 200, 200);
            do_frame("run miss", 2, 240, 200, 200);
        end
        check("game over reached", {13'd0, game_over}, 14'd1);
        do_frame("post away", 100, 240, 200, 200);
        do_frame("post miss", 2, 240, 200, 200);

        apply_reset();
        @(negedge clk);
        check("reset clears", outs(), 14'd0);

        // A scoring frame in flight is discarded by a reset in cycle t+1.
        do_frame("pre abort", 100, 240, 200, 200);
        @(posedge clk); #1;
        ball_x = 10'd2; ball_y = 10'd2; frame = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        check("abort outs", outs(), 14'd0);
        check("abort state", {12'd0, state}, {12'd0, ST_ARM});
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("abort idle", outs(), 14'd0);

        do_frame("after abort", 2, 240, 200, 200);

        check("scoreboard drained", {8'd0, 6'(exp_q.size())}, 14'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
